cla_pipe_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor. It is the successor to the 4-bit combinational CLA. Operands are split into GROUP-bit lookahead groups, with one group per pipeline stage, so carries ripple between stages through registers. It adds a valid/ready handshake on both sides, an add/subtract mode, and a signed-overflow flag. It sits in the datapath as a streaming arithmetic unit.

---
 rtl/cla_pipe_adder.sv | 140 ++++++++++++++
 tb/tb_cla_pipe_adder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshakes.
// One GROUP-bit lookahead group is resolved per stage; the group carry is
// registered into the next stage. Operand registers shrink and sum registers
// grow as the beat moves down the pipe, so each stage holds only live bits.
module cla_pipe_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned GROUP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned STAGES = WIDTH / GROUP;

   if ((WIDTH % GROUP) != 0) begin : g_bad_cfg
      $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
   end

   // Global advance: the whole pipe moves together or freezes together.
   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
      // Operand bits entering this stage (group k and everything above it).
      localparam int InW  = int'(WIDTH) - k * int'(GROUP);
      localparam int OpW  = InW - int'(GROUP);
      localparam int SumW = (k + 1) * int'(GROUP);

      logic [InW-1:0]   src_a;
      logic [InW-1:0]   src_bx;
      logic             c_in;
      logic             v_in;
      logic [GROUP-1:0] g;
      logic [GROUP-1:0] p;
      logic [GROUP:0]   c;
      logic             prod;
      logic [GROUP-1:0] grp_s;
      logic [SumW-1:0]  s_d;
      logic [SumW-1:0]  s_q;
      logic             c_q;
      logic             v_q;

      if (k == 0) begin : g_in
         // Subtract is A + ~B + 1; the mode is folded into B and the carry here.
         assign src_a  = a;
         assign src_bx = sub ? ~b : b;
         assign c_in   = sub | cin;
         assign v_in   = in_valid;
         assign s_d    = grp_s;
      end else begin : g_mid
         assign src_a  = g_stage[k-1].g_ops.op_a_q;
         assign src_bx = g_stage[k-1].g_ops.op_bx_q;
         assign c_in   = g_stage[k-1].c_q;
         assign v_in   = g_stage[k-1].v_q;
         assign s_d    = {grp_s, g_stage[k-1].s_q};
      end

      assign g = src_a[GROUP-1:0] & src_bx[GROUP-1:0];
      assign p = src_a[GROUP-1:0] ^ src_bx[GROUP-1:0];

      // Two-level lookahead: each carry is a sum of products of g/p and c_in.
      always_comb begin
         c    = '0;
         prod = 1'b0;
         c[0] = c_in;
         for (int i = 0; i < int'(GROUP); i++) begin
            prod = c_in;
            for (int m = 0; m <= i; m++) prod = prod & p[m];
            c[i+1] = prod;
            for (int j = 0; j <= i; j++) begin
               prod = g[j];
               for (int m = j + 1; m <= i; m++) prod = prod & p[m];
               c[i+1] = c[i+1] | prod;
            end
         end
      end

      assign grp_s = p ^ c[GROUP-1:0];

      // Stage valid, group carry-out and accumulated sum bits.
      always_ff @(posedge clk) begin
         if (rst) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else if (adv) begin
            v_q <= v_in;
            c_q <= c[GROUP];
            s_q <= s_d;
         end
      end

      if (OpW > 0) begin : g_ops
         logic [OpW-1:0] op_a_q;
         logic [OpW-1:0] op_bx_q;

         // Delay the not-yet-added upper operand groups alongside the beat.
         always_ff @(posedge clk) begin
            if (rst) begin
               op_a_q  <= '0;
               op_bx_q <= '0;
            end else if (adv) begin
               op_a_q  <= src_a[InW-1:GROUP];
               op_bx_q <= src_bx[InW-1:GROUP];
            end
         end
      end

      if (k == int'(STAGES) - 1) begin : g_last
         logic ovf_q;

         // Signed overflow: carry into the MSB differs from carry out of it.
         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else if (adv) begin
               ovf_q <= c[GROUP-1] ^ c[GROUP];
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].v_q;
   assign sum       = g_stage[STAGES-1].s_q;
   assign cout      = g_stage[STAGES-1].c_q;
   assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: three configurations (16/4, 4/4, 32/8) checked
// against an arithmetic reference model and a stamped scoreboard.
module tb_cla_pipe_adder;

   typedef struct {
      longint unsigned s;
      bit              co;
      bit              ov;
      int              stamp;
      int              stl;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t sb_q[$];

   logic        iv16 = 0, ir16, cin16 = 0, sub16 = 0, ov16, or16 = 1, co16, of16;
   logic [15:0] a16 = 0, b16 = 0, s16;
   logic        iv4 = 0, ir4, cin4 = 0, sub4 = 0, ov4, or4 = 1, co4, of4;
   logic [3:0]  a4 = 0, b4 = 0, s4;
   logic        iv32 = 0, ir32, cin32 = 0, sub32 = 0, ov32, or32 = 1, co32, of32;
   logic [31:0] a32 = 0, b32 = 0, s32;

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
      .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(s16),
      .cout(co16), .ovf(of16));

   cla_pipe_adder #(.WIDTH(4), .GROUP(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
      .cin(cin4), .sub(sub4), .out_valid(ov4), .out_ready(or4), .sum(s4),
      .cout(co4), .ovf(of4));

   cla_pipe_adder #(.WIDTH(32), .GROUP(8)) dut32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
      .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(s32),
      .cout(co32), .ovf(of32));

   // Reference: plain integer arithmetic, signed overflow by range check.
   function automatic void model(input int w, input longint unsigned ua, input longint unsigned ub,
                                 input bit ci, input bit sb, output longint unsigned s,
                                 output bit co, output bit ov);
      longint unsigned mask, u;
      longint hs, sa, sv, r;
      mask = (64'd1 << w) - 64'd1;
      hs   = longint'(64'd1 << (w - 1));
      sa   = longint'(ua);
      sv   = longint'(ub);
      if (sa >= hs) sa = sa - 2 * hs;
      if (sv >= hs) sv = sv - 2 * hs;
      if (!sb) begin
         u  = ua + ub + longint'(ci);
         co = ((u >> w) & 64'd1) != 0;
         s  = u & mask;
         r  = sa + sv + longint'(ci);
      end else begin
         co = ua >= ub;
         s  = (ua - ub) & mask;
         r  = sa - sv;
      end
      ov = (r >= hs) || (r < -hs);
   endfunction

   task automatic test_reset();
      rst  = 1'b1;
      or16 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (ov16 !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", ov16); end
      total++; if (s16 !== 16'h0) begin bad++; $display("FAIL reset_sum: got %h want 0000", s16); end
      total++; if ({co16, of16} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {co16, of16}); end
      rst = 1'b0;
      @(negedge clk);
      total++; if (ir16 !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", ir16); end
      total++; if ({ov4, ov32} !== 2'b00) begin bad++; $display("FAIL reset_other_valid: got %b want 00", {ov4, ov32}); end
      or16 = 1'b1;
   endtask

   task automatic test_wrap();
      int edges;
      @(negedge clk);
      iv16 = 1; a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 0; sub16 = 0;
      #1;
      total++; if (ir16 !== 1'b1) begin bad++; $display("FAIL wrap_in_ready: got %b want 1", ir16); end
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      iv16 = 0;
      while (!ov16 && edges < 20) begin
         @(posedge clk); edges++; @(negedge clk);
      end
      total++; if (edges != 4) begin bad++; $display("FAIL wrap_latency: got %0d want 4", edges); end
      total++; if ({co16, of16, s16} !== {2'b10, 16'h0000})
         begin bad++; $display("FAIL wrap_result: got %b %b %h want 1 0 0000", co16, of16, s16); end
      @(negedge clk);
      total++; if (ov16 !== 1'b0) begin bad++; $display("FAIL wrap_dup: got %b want 0", ov16); end
   endtask

   task automatic test_corners();
      logic [15:0] ta[3] = '{16'h7FFF, 16'h8000, 16'h0003};
      logic [15:0] tb[3] = '{16'h0001, 16'h0001, 16'h0005};
      logic        tc[3] = '{1'b0, 1'b0, 1'b1};
      logic        ts[3] = '{1'b0, 1'b1, 1'b1};
      logic [17:0] te[3] = '{{2'b01, 16'h8000}, {2'b11, 16'h7FFF}, {2'b00, 16'hFFFE}};
      int edges;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         iv16 = 1; a16 = ta[i]; b16 = tb[i]; cin16 = tc[i]; sub16 = ts[i];
         @(posedge clk);
         edges = 1;
         @(negedge clk);
         iv16 = 0; cin16 = ~cin16; sub16 = ~sub16;
         while (!ov16 && edges < 20) begin
            @(posedge clk); edges++; @(negedge clk);
         end
         total++; if ({co16, of16, s16} !== te[i] || edges != 4)
            begin bad++; $display("FAIL corner%0d: got %b %b %h lat %0d want %h lat 4", i, co16, of16, s16, edges, te[i]); end
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int sent = 0, got = 0;
      bit hold = 0;
      logic [15:0] hold_s = '0;
      exp_t e, r;
      sb_q.delete();
      for (int t = 0; t < 60 && got < 6; t++) begin
         @(negedge clk);
         if (hold) begin
            total++; if (ov16 !== 1'b1 || s16 !== hold_s)
               begin bad++; $display("FAIL b2b_stable: got %b %h want 1 %h", ov16, s16, hold_s); end
         end
         or16 = !(t >= 5 && t < 8);
         iv16 = sent < 6; a16 = 16'(sent); b16 = 16'(16'h1000 * sent); cin16 = sent[0]; sub16 = 0;
         #1;
         if (ov16 && !or16) begin
            total++; if (ir16 !== 1'b0) begin bad++; $display("FAIL b2b_in_ready: got %b want 0", ir16); end
         end
         hold = ov16 && !or16; hold_s = s16;
         if (iv16 && ir16) begin
            model(16, a16, b16, cin16, 1'b0, e.s, e.co, e.ov);
            sb_q.push_back(e); sent++;
         end
         if (ov16 && or16) begin
            got++;
            total++;
            if (sb_q.size() == 0) begin bad++; $display("FAIL b2b_extra: got %h want none", s16); end
            else begin
               r = sb_q.pop_front();
               if ({co16, of16, 64'(s16)} !== {r.co, r.ov, r.s})
                  begin bad++; $display("FAIL b2b_data: got %b %b %h want %b %b %h", co16, of16, s16, r.co, r.ov, r.s); end
            end
         end
      end
      total++; if (got != 6 || sent != 6) begin bad++; $display("FAIL b2b_count: got %0d/%0d want 6/6", got, sent); end
      iv16 = 0; or16 = 1;
      @(negedge clk);
      total++; if (ov16 !== 1'b0) begin bad++; $display("FAIL b2b_dup: got %b want 0", ov16); end
   endtask

   task automatic test_reset_flush();
      int edges, seen = 0;
      or16 = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         iv16 = 1; a16 = 16'(100 + i); b16 = 16'h0F00; cin16 = 0; sub16 = 0;
      end
      @(negedge clk);
      iv16 = 0; rst = 1;
      @(negedge clk);
      total++; if (ov16 !== 1'b0 || s16 !== 16'h0)
         begin bad++; $display("FAIL flush_reset: got %b %h want 0 0000", ov16, s16); end
      rst = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ov16) seen++;
      end
      total++; if (seen != 0) begin bad++; $display("FAIL flush_leak: got %0d beats want 0", seen); end
      iv16 = 1; a16 = 16'h1234; b16 = 16'h4321; cin16 = 0; sub16 = 0;
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      iv16 = 0;
      while (!ov16 && edges < 20) begin
         @(posedge clk); edges++; @(negedge clk);
      end
      total++; if (edges != 4 || {co16, of16, s16} !== {2'b00, 16'h5555})
         begin bad++; $display("FAIL flush_after: got %b %b %h lat %0d want 0 0 5555 lat 4", co16, of16, s16, edges); end
      @(negedge clk);
   endtask

   task automatic test_exhaustive4();
      int sent = 0, got = 0;
      exp_t e, r;
      sb_q.delete();
      or4 = 1;
      for (int t = 0; t < 700 && got < 512; t++) begin
         @(negedge clk);
         iv4 = sent < 512; a4 = 4'(sent & 15); b4 = 4'((sent >> 4) & 15); cin4 = sent[8]; sub4 = 0;
         #1;
         if (iv4 && ir4) begin
            model(4, a4, b4, cin4, 1'b0, e.s, e.co, e.ov);
            e.stamp = cyc; e.stl = 0;
            sb_q.push_back(e); sent++;
         end
         if (ov4 && or4) begin
            got++;
            total++;
            if (sb_q.size() == 0) begin bad++; $display("FAIL ex4_extra: got %h want none", s4); end
            else begin
               r = sb_q.pop_front();
               if ({co4, of4, 64'(s4)} !== {r.co, r.ov, r.s} || cyc - r.stamp != 1)
                  begin bad++; $display("FAIL ex4_data: got %b %b %h lat %0d want %b %b %h lat 1", co4, of4, s4, cyc - r.stamp, r.co, r.ov, r.s); end
            end
         end
      end
      iv4 = 0;
      total++; if (got != 512) begin bad++; $display("FAIL ex4_count: got %0d want 512", got); end
   endtask

   task automatic test_random32();
      int sent = 0, got = 0, stalls = 0;
      bit hold = 0;
      logic [31:0] hold_s = '0;
      exp_t e, r;
      sb_q.delete();
      for (int t = 0; t < 20000 && got < 1000; t++) begin
         @(negedge clk);
         if (hold) begin
            total++; if (ov32 !== 1'b1 || s32 !== hold_s)
               begin bad++; $display("FAIL rnd_stable: got %b %h want 1 %h", ov32, s32, hold_s); end
         end
         or32 = $urandom_range(0, 9) < 7;
         iv32 = (sent < 1000) && ($urandom_range(0, 3) != 0);
         a32 = $urandom; b32 = $urandom;
         if ($urandom_range(0, 7) == 0) a32 = 32'h8000_0000;
         if ($urandom_range(0, 7) == 0) b32 = 32'hFFFF_FFFF;
         cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
         #1;
         total++; if (ir32 !== (!ov32 || or32))
            begin bad++; $display("FAIL rnd_in_ready: got %b want %b", ir32, !ov32 || or32); end
         if (ov32 && !or32) stalls++;
         hold = ov32 && !or32; hold_s = s32;
         if (iv32 && ir32) begin
            model(32, a32, b32, cin32, sub32, e.s, e.co, e.ov);
            e.stamp = cyc; e.stl = stalls;
            sb_q.push_back(e); sent++;
         end
         if (ov32 && or32) begin
            got++;
            total++;
            if (sb_q.size() == 0) begin bad++; $display("FAIL rnd_extra: got %h want none", s32); end
            else begin
               r = sb_q.pop_front();
               if ({co32, of32, 64'(s32)} !== {r.co, r.ov, r.s} || cyc - r.stamp - (stalls - r.stl) != 4)
                  begin bad++; $display("FAIL rnd_data: got %b %b %h lat %0d want %b %b %h lat 4", co32, of32, s32, cyc - r.stamp - (stalls - r.stl), r.co, r.ov, r.s); end
            end
         end
      end
      iv32 = 0; or32 = 1;
      total++; if (got != 1000) begin bad++; $display("FAIL rnd_count: got %0d want 1000", got); end
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_corners();
      test_back_to_back();
      test_reset_flush();
      test_exhaustive4();
      test_random32();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
